// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : imem_load_ctrl
//  Purpose  : Owns the single address/write port of the instruction ROM.
//             In RUN the CPU fetch address goes straight to the ROM.  On a
//             load request the CPU is held, a UART byte stream is packed
//             little-endian into 32-bit words and written from word 0
//             upward, and the CPU is released once the stream goes idle.
//  Ports    : clock_i        system clock (posedge)
//             reset_i        synchronous reset, active low
//             load_req_i     enter load mode (honoured only in RUN)
//             rx_valid_i     one-cycle strobe qualifying rx_data_i
//             rx_data_i      received byte
//             fetch_addr_i   CPU fetch word address (PC[15:2])
//             imem_addr_o    ROM word address
//             imem_wdata_o   ROM write data (registered)
//             imem_we_o      ROM write enable, single-cycle pulses
//             cpu_hold_o     holds the CPU in reset while high (registered)
//             load_busy_o    high in every state except RUN
//             words_loaded_o words written by the current/last load
//             overflow_o     sticky: a word arrived after the ROM was full
//  Revision : 1.0  initial release
// ============================================================================
module imem_load_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              load_req_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              imem_we_o,
  output logic              cpu_hold_o,
  output logic              load_busy_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic              overflow_o
);

  localparam int              IDLE_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    ARM     = 3'd1,
    COLLECT = 3'd2,
    FLUSH   = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e              state_q,      state_d;
  logic [ADDR_W:0]     wr_ptr_q,     wr_ptr_d;
  logic [1:0]          byte_cnt_q,   byte_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q,   idle_cnt_d;
  logic [23:0]         assemble_q,   assemble_d;
  logic [31:0]         wdata_q,      wdata_d;
  logic                write_pend_q, write_pend_d;
  logic                cpu_hold_q,   cpu_hold_d;
  logic                overflow_q,   overflow_d;

  logic                write_slot;
  logic                rom_full;
  logic                byte_accept;

  // The pointer counts up to DEPTH inclusive; its MSB alone flags "full".
  assign rom_full    = wr_ptr_q[ADDR_W];
  // A word is retired either one cycle after its 4th byte or in FLUSH.
  assign write_slot  = write_pend_q | (state_q == FLUSH);
  assign byte_accept = rx_valid_i & ((state_q == ARM) | (state_q == COLLECT));

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    assemble_d   = assemble_q;
    wdata_d      = wdata_q;
    write_pend_d = 1'b0;
    cpu_hold_d   = cpu_hold_q;
    overflow_d   = overflow_q;

    // Retire a word: advance the pointer, or flag overflow when full.
    if (write_slot) begin
      if (rom_full) begin
        overflow_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // Byte packing runs alongside a pending write, so a back-to-back
    // stream never stalls.  The assembly register is cleared on each
    // completed word so that a later flush zero-pads the missing bytes.
    if (byte_accept) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      case (byte_cnt_q)
        2'd0: assemble_d[7:0]   = rx_data_i;
        2'd1: assemble_d[15:8]  = rx_data_i;
        2'd2: assemble_d[23:16] = rx_data_i;
        default: begin
          wdata_d      = {rx_data_i, assemble_q};
          write_pend_d = 1'b1;
          assemble_d   = 24'h0;
        end
      endcase
    end

    case (state_q)
      RUN: begin
        if (load_req_i) begin
          state_d    = ARM;
          cpu_hold_d = 1'b1;
          wr_ptr_d   = '0;
          byte_cnt_d = 2'd0;
          idle_cnt_d = '0;
          assemble_d = 24'h0;
          overflow_d = 1'b0;
        end
      end

      // No timeout here: the loader may take arbitrarily long to start.
      ARM: begin
        if (rx_valid_i) begin
          state_d    = COLLECT;
          idle_cnt_d = '0;
        end
      end

      COLLECT: begin
        if (rx_valid_i) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          // Hold at the limit until any pending write has retired.
          if (!write_pend_q) begin
            if (byte_cnt_q != 2'd0) begin
              state_d    = FLUSH;
              wdata_d    = {8'h00, assemble_q};
              byte_cnt_d = 2'd0;
              assemble_d = 24'h0;
            end else begin
              state_d = RELEASE;
            end
          end
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      FLUSH: begin
        state_d = RELEASE;
      end

      RELEASE: begin
        state_d    = RUN;
        cpu_hold_d = 1'b0;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q      <= RUN;
      wr_ptr_q     <= '0;
      byte_cnt_q   <= 2'd0;
      idle_cnt_q   <= '0;
      assemble_q   <= 24'h0;
      wdata_q      <= 32'h0;
      write_pend_q <= 1'b0;
      cpu_hold_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      assemble_q   <= assemble_d;
      wdata_q      <= wdata_d;
      write_pend_q <= write_pend_d;
      cpu_hold_q   <= cpu_hold_d;
      overflow_q   <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Outside RUN the ROM address is always the write pointer, which is
  // exactly what a write pulse needs and harmless otherwise.
  assign imem_addr_o    = (state_q == RUN) ? fetch_addr_i : wr_ptr_q[ADDR_W-1:0];
  assign imem_wdata_o   = wdata_q;
  assign imem_we_o      = write_slot & ~rom_full;
  assign cpu_hold_o     = cpu_hold_q;
  assign load_busy_o    = (state_q != RUN);
  // Words written always equals the write pointer, which is only
  // cleared by the next load request.
  assign words_loaded_o = wr_ptr_q;
  assign overflow_o     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_load_ctrl
//  Purpose  : Directed self-checking bench for imem_load_ctrl.  Two
//             instances share stimulus: a 14-bit-address one for the main
//             checks and a 2-bit-address one that fills up to exercise
//             overflow.  Both use a 16-cycle idle timeout.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_load_ctrl;

  localparam int TMO = 16;

  logic        clk;
  logic        reset_n;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [13:0] fetch_addr;

  logic [13:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_we;
  logic        cpu_hold;
  logic        load_busy;
  logic [14:0] words_loaded;
  logic        overflow;

  logic [1:0]  imem_addr_s;
  logic [31:0] imem_wdata_s;
  logic        imem_we_s;
  logic        cpu_hold_s;
  logic        load_busy_s;
  logic [2:0]  words_loaded_s;
  logic        overflow_s;

  int n_vec = 0;
  int n_err = 0;

  logic [13:0] wa[$];
  logic [31:0] wd[$];
  logic [1:0]  wa_s[$];
  logic [31:0] wd_s[$];

  imem_load_ctrl #(.ADDR_W(14), .TIMEOUT(TMO)) dut (
    .clock_i        (clk),
    .reset_i        (reset_n),
    .load_req_i     (load_req),
    .rx_valid_i     (rx_valid),
    .rx_data_i      (rx_data),
    .fetch_addr_i   (fetch_addr),
    .imem_addr_o    (imem_addr),
    .imem_wdata_o   (imem_wdata),
    .imem_we_o      (imem_we),
    .cpu_hold_o     (cpu_hold),
    .load_busy_o    (load_busy),
    .words_loaded_o (words_loaded),
    .overflow_o     (overflow)
  );

  imem_load_ctrl #(.ADDR_W(2), .TIMEOUT(TMO)) dut_s (
    .clock_i        (clk),
    .reset_i        (reset_n),
    .load_req_i     (load_req),
    .rx_valid_i     (rx_valid),
    .rx_data_i      (rx_data),
    .fetch_addr_i   (fetch_addr[1:0]),
    .imem_addr_o    (imem_addr_s),
    .imem_wdata_o   (imem_wdata_s),
    .imem_we_o      (imem_we_s),
    .cpu_hold_o     (cpu_hold_s),
    .load_busy_o    (load_busy_s),
    .words_loaded_o (words_loaded_s),
    .overflow_o     (overflow_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: imem_we is high for whole cycles, so one sample on the
  // falling edge captures each pulse exactly once.
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (imem_we_s) begin
      wa_s.push_back(imem_addr_s);
      wd_s.push_back(imem_wdata_s);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    wa_s.delete();
    wd_s.delete();
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[], input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = b[i];
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Counts edges from now until load_busy falls, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (load_busy && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("busy_cleared", {31'b0, load_busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [7:0] bytes[];
    bytes = new[20];

    reset_n    = 1'b0;
    load_req   = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    fetch_addr = 14'h0123;

    // ---------------- Reset then RUN ----------------
    tick();
    tick();
    chk("rst_we",       {31'b0, imem_we},     32'h0);
    chk("rst_hold",     {31'b0, cpu_hold},    32'h0);
    chk("rst_wdata",    imem_wdata,           32'h0);
    reset_n = 1'b1;
    tick();
    chk("run_addr",     {18'b0, imem_addr},   32'h0123);
    chk("run_we",       {31'b0, imem_we},     32'h0);
    chk("run_hold",     {31'b0, cpu_hold},    32'h0);
    chk("run_busy",     {31'b0, load_busy},   32'h0);
    chk("run_words",    {17'b0, words_loaded}, 32'h0);
    chk("run_ovf",      {31'b0, overflow},    32'h0);

    // ---------------- Full-word load ----------------
    clear_mon();
    pulse_load_req();
    chk("fw_hold",      {31'b0, cpu_hold},    32'h1);
    chk("fw_busy",      {31'b0, load_busy},   32'h1);
    repeat (40) tick();
    chk("arm_no_tmo",   {31'b0, load_busy},   32'h1);
    chk("arm_no_write", wd.size(),            32'd0);
    bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
    bytes[4] = 8'hEF; bytes[5] = 8'hBE; bytes[6] = 8'hAD; bytes[7] = 8'hDE;
    send_bytes(bytes, 8);
    wait_done(cyc);
    chk("fw_latency",   cyc,                  32'd17);
    chk("fw_nwrites",   wd.size(),            32'd2);
    if (wd.size() == 2) begin
      chk("fw_a0", {18'b0, wa[0]}, 32'd0);
      chk("fw_d0", wd[0],          32'h12345678);
      chk("fw_a1", {18'b0, wa[1]}, 32'd1);
      chk("fw_d1", wd[1],          32'hDEADBEEF);
    end
    chk("fw_words",     {17'b0, words_loaded}, 32'd2);
    chk("fw_hold_off",  {31'b0, cpu_hold},    32'h0);
    chk("fw_addr_back", {18'b0, imem_addr},   32'h0123);
    repeat (3) tick();
    chk("fw_words_hold", {17'b0, words_loaded}, 32'd2);

    // ---------------- Partial-word flush ----------------
    clear_mon();
    pulse_load_req();
    chk("pw_words_clr", {17'b0, words_loaded}, 32'd0);
    for (int i = 0; i < 5; i++) bytes[i] = 8'(i + 1);
    send_bytes(bytes, 5);
    wait_done(cyc);
    chk("pw_latency",   cyc,                  32'd18);
    chk("pw_nwrites",   wd.size(),            32'd2);
    if (wd.size() == 2) begin
      chk("pw_a0", {18'b0, wa[0]}, 32'd0);
      chk("pw_d0", wd[0],          32'h04030201);
      chk("pw_a1", {18'b0, wa[1]}, 32'd1);
      chk("pw_d1", wd[1],          32'h00000005);
    end
    chk("pw_words",     {17'b0, words_loaded}, 32'd2);

    // ---------------- Overflow (small instance) ----------------
    clear_mon();
    pulse_load_req();
    for (int i = 0; i < 20; i++) bytes[i] = 8'(i + 1);
    send_bytes(bytes, 20);
    wait_done(cyc);
    chk("ov_nwrites",   wd_s.size(),          32'd4);
    if (wd_s.size() == 4) begin
      chk("ov_a0", {30'b0, wa_s[0]}, 32'd0);
      chk("ov_d0", wd_s[0],          32'h04030201);
      chk("ov_a1", {30'b0, wa_s[1]}, 32'd1);
      chk("ov_d1", wd_s[1],          32'h08070605);
      chk("ov_a2", {30'b0, wa_s[2]}, 32'd2);
      chk("ov_d2", wd_s[2],          32'h0C0B0A09);
      chk("ov_a3", {30'b0, wa_s[3]}, 32'd3);
      chk("ov_d3", wd_s[3],          32'h100F0E0D);
    end
    chk("ov_flag",      {31'b0, overflow_s},  32'h1);
    chk("ov_words",     {29'b0, words_loaded_s}, 32'd4);
    chk("ov_big_writes", wd.size(),           32'd5);
    chk("ov_big_flag",  {31'b0, overflow},    32'h0);
    chk("ov_big_words", {17'b0, words_loaded}, 32'd5);
    pulse_load_req();
    chk("ov_clear",     {31'b0, overflow_s},  32'h0);

    // ---------------- Reset mid-load ----------------
    for (int i = 0; i < 6; i++) bytes[i] = 8'(8'h30 + i);
    send_bytes(bytes, 6);
    clear_mon();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mr_hold",      {31'b0, cpu_hold},    32'h0);
    chk("mr_busy",      {31'b0, load_busy},   32'h0);
    chk("mr_words",     {17'b0, words_loaded}, 32'd0);
    repeat (TMO + 4) tick();
    chk("mr_nwrites",   wd.size(),            32'd0);
    chk("mr_busy_late", {31'b0, load_busy},   32'h0);

    // ---------------- Ignored events ----------------
    clear_mon();
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    send_bytes(bytes, 3);
    chk("ig_run_busy",  {31'b0, load_busy},   32'h0);
    chk("ig_run_write", wd.size(),            32'd0);
    pulse_load_req();
    bytes[0] = 8'hA1; bytes[1] = 8'hB2;
    send_bytes(bytes, 2);
    pulse_load_req();
    chk("ig_req_busy",  {31'b0, load_busy},   32'h1);
    bytes[0] = 8'hC3; bytes[1] = 8'hD4;
    send_bytes(bytes, 2);
    wait_done(cyc);
    chk("ig_latency",   cyc,                  32'd17);
    chk("ig_nwrites",   wd.size(),            32'd1);
    if (wd.size() == 1) begin
      chk("ig_a0", {18'b0, wa[0]}, 32'd0);
      chk("ig_d0", wd[0],          32'hD4C3B2A1);
    end
    chk("ig_words",     {17'b0, words_loaded}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
